// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit / request-to-send, bit shifting on
// device clock falling edges, odd parity, stop bit, ACK check and timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 6500,
  parameter int START_TIMEOUT_CYCLES = 975000,
  parameter int BIT_TIMEOUT_CYCLES   = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int MAX_AB     = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : START_TIMEOUT_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > BIT_TIMEOUT_CYCLES) ? MAX_AB : BIT_TIMEOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] BIT_LAST     = TW'(BIT_TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_START, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_FAIL
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic          data_bit;
  logic          ready_q;
  logic          clk_s1, clk_s2, clk_s3, data_s1, data_s2;
  logic          fe, accept, bit_phase;

  assign fe        = clk_s3 & ~clk_s2;
  assign accept    = (state == S_IDLE) && tx_valid && ready_q;
  assign bit_phase = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign tx_ready  = ready_q;
  assign busy      = (state != S_IDLE);
  assign tx_done   = (state == S_DONE);
  assign tx_error  = (state == S_FAIL);

  // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == S_IDLE);
    end
  end

  // One shared timer: restarts on every state change and on each device edge
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || state_next != state || (bit_phase && fe))
      timer <= '0;
    else
      timer <= timer + TW'(1);
  end

  // frame = {stop, parity, d7..d0}; each device falling edge presents the next bit
  always_ff @(posedge clk) begin
    if (rst) begin
      frame    <= '0;
      bit_idx  <= '0;
      data_bit <= 1'b1;
    end else if (accept) begin
      frame    <= {1'b1, ~^tx_data, tx_data};
      bit_idx  <= '0;
      data_bit <= 1'b1;
    end else if (fe && (state == S_REQ || state == S_SEND)) begin
      data_bit <= frame[bit_idx];
      bit_idx  <= bit_idx + 4'd1;
    end
  end

  always_comb begin
    state_next  = state;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (timer == INHIBIT_LAST) state_next = S_START;
      end
      S_START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_next  = S_REQ;
      end
      S_REQ: begin
        ps2_data_oe = 1'b1;
        if (fe)                       state_next = S_SEND;
        else if (timer == START_LAST) state_next = S_FAIL;
      end
      S_SEND: begin
        ps2_data_oe = ~data_bit;
        if (fe && bit_idx == 4'd9)  state_next = S_ACK;
        else if (!fe && timer == BIT_LAST) state_next = S_FAIL;
      end
      S_ACK: begin
        if (fe)                     state_next = data_s2 ? S_FAIL : S_WAIT_IDLE;
        else if (timer == BIT_LAST) state_next = S_FAIL;
      end
      S_WAIT_IDLE: begin
        if (clk_s2 && data_s2)      state_next = S_DONE;
        else if (timer == BIT_LAST) state_next = S_FAIL;
      end
      S_DONE:  state_next = S_IDLE;
      S_FAIL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the open-collector PS/2 clock/data lines.
- Sits beside the PS/2 receiver in the keyboard subsystem, upstream of the key decoder, which consumes the received frames.
- Implements the inhibit/request-to-send sequence, bit shifting on device clock edges, odd parity, stop bit, ACK check and timeouts.
- Asserts busy so the receiver can ignore line activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 6500, clk cycles to hold ps2 clock low (100 us at 65 MHz).
- START_TIMEOUT_CYCLES, 975000, maximum wait for the first device falling edge after the request (15 ms).
- BIT_TIMEOUT_CYCLES, 65000, maximum gap between consecutive device falling edges (1 ms).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- tx_data  input  8  command byte
- tx_valid  input  1  request to send tx_data
- tx_ready  output  1  high when the block can accept a byte
- ps2_clk_in  input  1  raw PS/2 clock line (asynchronous)
- ps2_data_in  input  1  raw PS/2 data line (asynchronous)
- ps2_clk_oe  output  1  1 = pull PS/2 clock low, 0 = release
- ps2_data_oe  output  1  1 = pull PS/2 data low, 0 = release
- busy  output  1  high in every state except IDLE
- tx_done  output  1  one-cycle pulse: frame ACKed by the device
- tx_error  output  1  one-cycle pulse: missing ACK or timeout

Behaviour:
- Reset values: tx_ready=1 only after reset deasserts. During reset tx_ready=0, busy=0, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_error=0, state=IDLE, all counters 0.
- Reset mid-frame releases both lines on the next clk edge.
- Inputs pass through 2-FF synchronisers. A falling edge (fe) is synchronised clk previous=1 and current=0, producing a single-cycle strobe.
- Handshake:
  - Accept on tx_valid && tx_ready in IDLE.
  - Latch tx_data, compute parity = ~^tx_data (odd parity).
  - tx_ready drops the cycle after accept and rises again in IDLE.
  - tx_valid outside IDLE is ignored.
- IDLE: both oe=0. On accept go to INHIBIT and load the counter.
- INHIBIT:
  - clk_oe=1, data_oe=0 for INHIBIT_CYCLES.
  - Then data_oe=1 (start bit) while clk_oe stays 1 for one cycle.
  - Then clk_oe=0 and go to REQ.
- REQ:
  - data_oe=1, waiting for fe.
  - fe: drive bit0 (data_oe = ~bit0), bit index=1, go to SEND.
  - No fe within START_TIMEOUT_CYCLES: go to FAIL.
- SEND (data only changes on fe, while the device clock is low):
  - Each fe drives the next data bit, d1..d7 in order.
  - Next fe drives parity (data_oe = ~parity).
  - Next fe releases data (stop bit, data_oe=0) and goes to ACK.
- ACK: on fe, sample synchronised data:
  - 0 → WAIT_IDLE.
  - 1 → FAIL.
- WAIT_IDLE: wait until synchronised clk=1 and data=1, then go to DONE.
- DONE: tx_done=1 for one cycle, then IDLE.
- FAIL: release both lines, tx_error=1 for one cycle, then IDLE.
- Timeouts:
  - Bit timer is cleared on every fe in SEND, ACK and WAIT_IDLE.
  - Reaching BIT_TIMEOUT_CYCLES in those states goes to FAIL.
  - Counter width = $clog2 of the largest parameter + 1.
- tx_done and tx_error are never high in the same cycle.
- No glitch filter; the line conditioning upstream guarantees clean edges.

Test Plan:
- Send 0xF4 with a device model clocking at 12.5 kHz and ACKing:
  - clk_oe high for exactly 6500 cycles, then start bit 0.
  - Device samples 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - tx_done pulses once, and busy falls the same cycle tx_ready rises.
- Send 0xED:
  - Bits 1,0,1,1,0,1,1,1, parity 1 (popcount 6).
  - ACK → tx_done.
- Device never clocks after the request → tx_error exactly 975000 cycles after REQ entry; both oe=0.
- Device stops clocking after bit 3 → tx_error 65000 cycles after the last fe; no tx_done.
- Device leaves data high on the ACK edge → tx_error pulse; lines released.
- rst asserted during SEND of 0xFF → next cycle oe=0, busy=0.
- After rst releases, a new 0x00 frame completes with parity 1.
